// File: rtl/result_argmax.sv
// result_argmax
//   Consumer end of the FC2 output interface. On a rising edge of the FC2 done
//   level it snapshots all class scores, then walks them one compare per cycle
//   to find the largest sign-magnitude score and posts its index and value.
//
// Ports
//   clk       rising-edge clock
//   iRst_n    asynchronous active-low reset
//   ena       block enable; low forces IDLE and clears oValid (results hold)
//   iStart    FC2 done level; a 0->1 edge starts a classification
//   iScores   NUM_CLASS packed sign-magnitude words, word 0 in the LSBs
//   oBusy     high from capture until the result is posted
//   oValid    result valid; holds until next start edge, ena low or reset
//   oDigit    index of the maximum score
//   oScore    maximum score word, unmodified
//   oDigit2   runner-up index        (ARGMAX_RUNNER_UP_EN only)
//   oScore2   runner-up score word   (ARGMAX_RUNNER_UP_EN only)
//
// Build option
//   ARGMAX_RUNNER_UP_EN : also track the second-highest class in the same pass.
module result_argmax #(
  parameter int DATA_W    = 16,
  parameter int NUM_CLASS = 10
) (
  input  logic                        clk,
  input  logic                        iRst_n,
  input  logic                        ena,
  input  logic                        iStart,
  input  logic [NUM_CLASS*DATA_W-1:0] iScores,
  output logic                        oBusy,
  output logic                        oValid,
  output logic [3:0]                  oDigit,
  output logic [DATA_W-1:0]           oScore
`ifdef ARGMAX_RUNNER_UP_EN
  ,
  output logic [3:0]                  oDigit2,
  output logic [DATA_W-1:0]           oScore2
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, POST, HOLD} state_t;

  state_t              state, state_nxt;
  logic                start_prev;
  logic                armed;
  logic                start_edge;
  logic                capture;
  logic [DATA_W-1:0]   bank [NUM_CLASS];
  logic [DATA_W-1:0]   best;
  logic [3:0]          best_idx;
  logic [3:0]          idx;
  logic [DATA_W-1:0]   cur_word;
  logic                cur_gt_best;
`ifdef ARGMAX_RUNNER_UP_EN
  logic [DATA_W-1:0]   best2;
  logic [3:0]          best2_idx;
  logic                cur_gt_best2;
`endif

  // Map sign-magnitude onto a two's complement key so +0 and -0 compare equal
  // and ordinary signed comparison gives the class ordering.
  function automatic logic signed [DATA_W:0] sm_key(input logic [DATA_W-1:0] w);
    logic signed [DATA_W:0] mag;
    mag = $signed({2'b00, w[DATA_W-2:0]});
    return w[DATA_W-1] ? -mag : mag;
  endfunction

  // armed stays low for the first cycle after reset release, so a done level
  // that was already high while in reset is absorbed into start_prev instead
  // of being mistaken for a fresh edge.
  assign start_edge  = armed & iStart & ~start_prev;
  assign capture     = ena && ((state == IDLE) || (state == HOLD)) && start_edge;
  assign cur_word    = bank[idx];
  assign cur_gt_best = sm_key(cur_word) > sm_key(best);
`ifdef ARGMAX_RUNNER_UP_EN
  assign cur_gt_best2 = sm_key(cur_word) > sm_key(best2);
`endif

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, HOLD: if (start_edge)      state_nxt = SCAN;
        SCAN:       if (idx == LAST_IDX) state_nxt = POST;
        POST:                            state_nxt = HOLD;
        default:                         state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      start_prev <= 1'b0;
      armed      <= 1'b0;
      oBusy      <= 1'b0;
      oValid     <= 1'b0;
      oDigit     <= '0;
      oScore     <= '0;
      best       <= '0;
      best_idx   <= '0;
      idx        <= '0;
      for (int k = 0; k < NUM_CLASS; k++) bank[k] <= '0;
`ifdef ARGMAX_RUNNER_UP_EN
      best2      <= '0;
      best2_idx  <= '0;
      oDigit2    <= '0;
      oScore2    <= '0;
`endif
    end else begin
      start_prev <= iStart;
      armed      <= 1'b1;
      if (!ena) begin
        oBusy  <= 1'b0;
        oValid <= 1'b0;
      end else if (capture) begin
        for (int k = 0; k < NUM_CLASS; k++) bank[k] <= iScores[DATA_W*k +: DATA_W];
        best     <= iScores[DATA_W-1:0];
        best_idx <= '0;
        idx      <= 4'd1;
        oBusy    <= 1'b1;
        oValid   <= 1'b0;
`ifdef ARGMAX_RUNNER_UP_EN
        best2     <= {1'b1, {(DATA_W-1){1'b1}}};
        best2_idx <= '0;
`endif
      end else if (state == SCAN) begin
        // Strict greater-than keeps the lowest index on ties.
        if (cur_gt_best) begin
          best     <= cur_word;
          best_idx <= idx;
`ifdef ARGMAX_RUNNER_UP_EN
          best2     <= best;
          best2_idx <= best_idx;
        end else if (cur_gt_best2) begin
          best2     <= cur_word;
          best2_idx <= idx;
`endif
        end
        idx <= idx + 4'd1;
      end else if (state == POST) begin
        oDigit <= best_idx;
        oScore <= best;
        oValid <= 1'b1;
        oBusy  <= 1'b0;
`ifdef ARGMAX_RUNNER_UP_EN
        oDigit2 <= best2_idx;
        oScore2 <= best2;
`endif
      end
    end
  end

endmodule

// File: tb/tb_result_argmax.sv
module tb_result_argmax;

  localparam int DATA_W    = 16;
  localparam int NUM_CLASS = 10;

  logic                        clk = 1'b0;
  logic                        iRst_n;
  logic                        ena;
  logic                        iStart;
  logic [NUM_CLASS*DATA_W-1:0] iScores;
  logic                        oBusy;
  logic                        oValid;
  logic [3:0]                  oDigit;
  logic [DATA_W-1:0]           oScore;
`ifdef ARGMAX_RUNNER_UP_EN
  logic [3:0]                  oDigit2;
  logic [DATA_W-1:0]           oScore2;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [DATA_W-1:0] sc [NUM_CLASS];

  result_argmax #(.DATA_W(DATA_W), .NUM_CLASS(NUM_CLASS)) dut (
    .clk     (clk),
    .iRst_n  (iRst_n),
    .ena     (ena),
    .iStart  (iStart),
    .iScores (iScores),
    .oBusy   (oBusy),
    .oValid  (oValid),
    .oDigit  (oDigit),
    .oScore  (oScore)
`ifdef ARGMAX_RUNNER_UP_EN
    ,
    .oDigit2 (oDigit2),
    .oScore2 (oScore2)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack_scores;
    for (int k = 0; k < NUM_CLASS; k++) iScores[DATA_W*k +: DATA_W] = sc[k];
  endtask

  task automatic fill(input logic [DATA_W-1:0] v);
    for (int k = 0; k < NUM_CLASS; k++) sc[k] = v;
  endtask

  // Raise iStart (edge sampled on the next clock), wait the full 11 clocks
  // to the posted result, then drop iStart again.
  task automatic run_and_check(input string tag, input logic [3:0] dig, input logic [DATA_W-1:0] scr);
    pack_scores();
    iStart = 1'b1;
    tick(11);
    check({tag, "_valid"}, 32'(oValid), 32'd1);
    check({tag, "_digit"}, 32'(oDigit), 32'(dig));
    check({tag, "_score"}, 32'(oScore), 32'(scr));
    iStart = 1'b0;
    tick(1);
  endtask

  initial begin
    iRst_n  = 1'b0;
    ena     = 1'b1;
    iStart  = 1'b0;
    iScores = '0;
    #3;
    check("rst_busy",  32'(oBusy),  32'd0);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_digit", 32'(oDigit), 32'd0);
    check("rst_score", 32'(oScore), 32'd0);
    #4 iRst_n = 1'b1;
    tick(2);

    // Ascending scores: max at word 9, with exact latency checks.
    for (int k = 0; k < NUM_CLASS; k++) sc[k] = 16'(k * 16'h0010);
    pack_scores();
    iStart = 1'b1;
    tick(1);
    check("t1_busy_after_edge", 32'(oBusy), 32'd1);
    tick(9);
    check("t1_valid_at_n9", 32'(oValid), 32'd0);
    tick(1);
    check("t1_valid_at_n10", 32'(oValid), 32'd1);
    check("t1_busy_done",    32'(oBusy),  32'd0);
    check("t1_digit",        32'(oDigit), 32'd9);
    check("t1_score",        32'(oScore), 32'h0090);
    iStart = 1'b0;
    tick(1);

    // All negative: smallest magnitude wins.
    fill(16'h8100); sc[3] = 16'h8001;
    run_and_check("t2_neg", 4'd3, 16'h8001);

    // Ties keep the lower index.
    fill(16'h0100); sc[2] = 16'h0400; sc[7] = 16'h0400;
    run_and_check("t3_tie", 4'd2, 16'h0400);

    // -0 equals +0, so word 0 stays.
    fill(16'h0000); sc[0] = 16'h8000;
    run_and_check("t3_zero", 4'd0, 16'h8000);

    // Small positive beats large-magnitude negatives.
    fill(16'hFFFF); sc[4] = 16'h0001;
    run_and_check("t3_posneg", 4'd4, 16'h0001);

    // Reset mid-scan aborts; level still high after release must not restart.
    fill(16'h0100); sc[8] = 16'h0800;
    pack_scores();
    iStart = 1'b1;
    tick(6);
    iRst_n = 1'b0;
    #1;
    check("t4_busy_async",  32'(oBusy),  32'd0);
    check("t4_valid_async", 32'(oValid), 32'd0);
    check("t4_digit_async", 32'(oDigit), 32'd0);
    check("t4_score_async", 32'(oScore), 32'd0);
    #2 iRst_n = 1'b1;
    tick(15);
    check("t4_no_rerun_valid", 32'(oValid), 32'd0);
    check("t4_no_rerun_busy",  32'(oBusy),  32'd0);

    // Second edge during SCAN ignored; score changes after capture ignored.
    iStart = 1'b0;
    tick(1);
    fill(16'h0100); sc[6] = 16'h0700;
    pack_scores();
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    tick(3);
    iStart = 1'b1;
    sc[1] = 16'h7FFF;
    pack_scores();
    tick(1);
    tick(5);
    check("t5_valid_at_n9", 32'(oValid), 32'd0);
    tick(1);
    check("t5_valid_at_n10", 32'(oValid), 32'd1);
    check("t5_digit",        32'(oDigit), 32'd6);
    check("t5_score",        32'(oScore), 32'h0700);

    // Edge in HOLD re-captures: oValid drops next cycle.
    iStart = 1'b0;
    tick(1);
    fill(16'h0100); sc[5] = 16'h0555;
    pack_scores();
    iStart = 1'b1;
    tick(1);
    check("t5_hold_valid_drop", 32'(oValid), 32'd0);
    check("t5_hold_busy",       32'(oBusy),  32'd1);
    tick(9);
    check("t5_hold_valid_n9", 32'(oValid), 32'd0);
    tick(1);
    check("t5_hold_valid", 32'(oValid), 32'd1);
    check("t5_hold_digit", 32'(oDigit), 32'd5);
    check("t5_hold_score", 32'(oScore), 32'h0555);

    // ena low clears valid, holds result; level held through ena low does not retrigger.
    ena = 1'b0;
    tick(1);
    check("ena_valid", 32'(oValid), 32'd0);
    check("ena_digit", 32'(oDigit), 32'd5);
    ena = 1'b1;
    tick(13);
    check("ena_no_retrigger", 32'(oValid), 32'd0);
    check("ena_not_busy",     32'(oBusy),  32'd0);
    iStart = 1'b0;
    tick(1);

`ifdef ARGMAX_RUNNER_UP_EN
    fill(16'h8000); sc[0] = 16'h0100; sc[1] = 16'h0300; sc[2] = 16'h0200;
    run_and_check("t6_ru", 4'd1, 16'h0300);
    check("t6_digit2", 32'(oDigit2), 32'd2);
    check("t6_score2", 32'(oScore2), 32'h0200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
